error_status_tracker: RTL and testbench

//  - Sequential stage directly downstream of the calculator error encoder.
//  - Samples the 2-bit error code (bit1 = adder-subtractor overflow, bit0 = divide/modulo by zero)

---
 rtl/error_status_tracker.sv | 107 ++++++++++
 tb/tb_error_status_tracker.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/error_status_tracker.sv
// Error status stage after the calculator error encoder: holds the first unacknowledged error, sticky flags, optional counters (ERR_COUNT_EN).
// Latency: all outputs registered, one cycle after the sampling edge; no combinational input-to-output paths.
// Backpressure: none; an error arriving while one is pending is recorded only in err_sticky/err_lost (and the counters).
module error_status_tracker #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic [1:0]       err_code,
    input  logic             clear,
    input  logic             rd_ack,
    output logic             err_pending,
    output logic [1:0]       err_latched,
    output logic [1:0]       err_sticky,
    output logic             err_lost,
    output logic [CNT_W-1:0] ovf_count,
    output logic [CNT_W-1:0] dbz_count
);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } stateT;

    stateT      state;
    stateT      stateNext;
    logic [1:0] latchedNext;
    logic       lostNext;
    logic       errEvent;

    assign errEvent    = op_valid && (err_code != 2'b00);
    assign err_pending = (state == PENDING);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state       <= IDLE;
            err_latched <= 2'b00;
            err_sticky  <= 2'b00;
            err_lost    <= 1'b0;
        end else begin
            state       <= stateNext;
            err_latched <= latchedNext;
            err_lost    <= lostNext;
            if (errEvent) begin
                err_sticky <= err_sticky | err_code;
            end
        end
    end

    always_comb begin
        stateNext   = state;
        latchedNext = err_latched;
        lostNext    = err_lost;
        case (state)
            IDLE: begin
                if (errEvent) begin
                    latchedNext = err_code;
                    stateNext   = PENDING;
                end
            end
            PENDING: begin
                // An ack in the same cycle as a new error retires the old one first,
                // so the new code takes its place and nothing is lost.
                if (rd_ack && !errEvent) begin
                    latchedNext = 2'b00;
                    stateNext   = IDLE;
                end else if (rd_ack && errEvent) begin
                    latchedNext = err_code;
                end else if (errEvent) begin
                    lostNext = 1'b1;
                end
            end
            default: begin
                stateNext   = IDLE;
                latchedNext = 2'b00;
            end
        endcase
    end

`ifdef ERR_COUNT_EN
    logic [CNT_W-1:0] ovfCnt;
    logic [CNT_W-1:0] dbzCnt;

    // Saturating counters: hold at all-ones rather than wrap.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            ovfCnt <= '0;
            dbzCnt <= '0;
        end else begin
            if (errEvent && err_code[1] && (ovfCnt != {CNT_W{1'b1}})) begin
                ovfCnt <= ovfCnt + 1'b1;
            end
            if (errEvent && err_code[0] && (dbzCnt != {CNT_W{1'b1}})) begin
                dbzCnt <= dbzCnt + 1'b1;
            end
        end
    end

    assign ovf_count = ovfCnt;
    assign dbz_count = dbzCnt;
`else
    assign ovf_count = '0;
    assign dbz_count = '0;
`endif

endmodule

// File: tb/tb_error_status_tracker.sv
// Directed bench for error_status_tracker (CNT_W=4); counter expectations follow ERR_COUNT_EN.
module tb_error_status_tracker;

    localparam int CNT_W = 4;
`ifdef ERR_COUNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             op_valid;
    logic [1:0]       err_code;
    logic             clear;
    logic             rd_ack;
    logic             err_pending;
    logic [1:0]       err_latched;
    logic [1:0]       err_sticky;
    logic             err_lost;
    logic [CNT_W-1:0] ovf_count;
    logic [CNT_W-1:0] dbz_count;

    int checks = 0;
    int errors = 0;

    error_status_tracker #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .op_valid    (op_valid),
        .err_code    (err_code),
        .clear       (clear),
        .rd_ack      (rd_ack),
        .err_pending (err_pending),
        .err_latched (err_latched),
        .err_sticky  (err_sticky),
        .err_lost    (err_lost),
        .ovf_count   (ovf_count),
        .dbz_count   (dbz_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] cexp(input int v);
        return CNT_ON ? 32'(v) : 32'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic pend, input logic [1:0] lat,
                            input logic [1:0] sticky, input logic lost, input int ovf, input int dbz);
        check({tag, ".pending"}, 32'(err_pending), 32'(pend));
        check({tag, ".latched"}, 32'(err_latched), 32'(lat));
        check({tag, ".sticky"},  32'(err_sticky),  32'(sticky));
        check({tag, ".lost"},    32'(err_lost),    32'(lost));
        check({tag, ".ovf"},     32'(ovf_count),   cexp(ovf));
        check({tag, ".dbz"},     32'(dbz_count),   cexp(dbz));
    endtask

    task automatic drive(input logic v, input logic [1:0] c, input logic ack, input logic clr);
        op_valid = v;
        err_code = c;
        rd_ack   = ack;
        clear    = clr;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b1, 2'b10, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        drive(1'b0, 2'b00, 1'b0, 1'b0);
        checkAll("reset", 1'b0, 2'b00, 2'b00, 1'b0, 0, 0);
        tick();
        checkAll("idle_after_reset", 1'b0, 2'b00, 2'b00, 1'b0, 0, 0);

        drive(1'b0, 2'b00, 1'b1, 1'b0);
        tick();
        checkAll("ack_in_idle", 1'b0, 2'b00, 2'b00, 1'b0, 0, 0);

        drive(1'b1, 2'b01, 1'b0, 1'b0);
        tick();
        checkAll("latch_01", 1'b1, 2'b01, 2'b01, 1'b0, 0, 1);
        drive(1'b0, 2'b00, 1'b1, 1'b0);
        tick();
        checkAll("ack_01", 1'b0, 2'b00, 2'b01, 1'b0, 0, 1);

        drive(1'b1, 2'b10, 1'b0, 1'b0);
        tick();
        checkAll("latch_10", 1'b1, 2'b10, 2'b11, 1'b0, 1, 1);
        drive(1'b1, 2'b01, 1'b0, 1'b0);
        tick();
        checkAll("lost_01", 1'b1, 2'b10, 2'b11, 1'b1, 1, 2);
        drive(1'b0, 2'b11, 1'b0, 1'b0);
        tick();
        checkAll("invalid_ignored", 1'b1, 2'b10, 2'b11, 1'b1, 1, 2);

        drive(1'b0, 2'b00, 1'b0, 1'b1);
        tick();
        checkAll("clear", 1'b0, 2'b00, 2'b00, 1'b0, 0, 0);
        drive(1'b1, 2'b01, 1'b0, 1'b0);
        tick();
        checkAll("latch_01b", 1'b1, 2'b01, 2'b01, 1'b0, 0, 1);
        drive(1'b1, 2'b10, 1'b1, 1'b0);
        tick();
        checkAll("ack_with_ev", 1'b1, 2'b10, 2'b11, 1'b0, 1, 1);
        drive(1'b0, 2'b00, 1'b1, 1'b0);
        tick();
        checkAll("ack_10", 1'b0, 2'b00, 2'b11, 1'b0, 1, 1);

        drive(1'b1, 2'b01, 1'b0, 1'b0);
        tick();
        drive(1'b1, 2'b10, 1'b0, 1'b0);
        tick();
        checkAll("lost_10", 1'b1, 2'b01, 2'b11, 1'b1, 2, 2);
        drive(1'b1, 2'b11, 1'b0, 1'b1);
        tick();
        checkAll("clear_vs_ev", 1'b0, 2'b00, 2'b00, 1'b0, 0, 0);

        drive(1'b1, 2'b11, 1'b0, 1'b0);
        tick();
        checkAll("latch_11", 1'b1, 2'b11, 2'b11, 1'b0, 1, 1);
        drive(1'b0, 2'b00, 1'b1, 1'b0);
        tick();
        checkAll("ack_11", 1'b0, 2'b00, 2'b11, 1'b0, 1, 1);

        drive(1'b0, 2'b00, 1'b0, 1'b1);
        tick();
        drive(1'b1, 2'b11, 1'b0, 1'b0);
        for (int i = 0; i < 14; i++) tick();
        checkAll("sat_14", 1'b1, 2'b11, 2'b11, 1'b1, 14, 14);
        tick();
        checkAll("sat_15", 1'b1, 2'b11, 2'b11, 1'b1, 15, 15);
        for (int i = 0; i < 5; i++) tick();
        checkAll("sat_20", 1'b1, 2'b11, 2'b11, 1'b1, 15, 15);
        drive(1'b0, 2'b11, 1'b0, 1'b0);
        tick();
        checkAll("sat_no_valid", 1'b1, 2'b11, 2'b11, 1'b1, 15, 15);

        rst = 1'b1;
        drive(1'b1, 2'b11, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        drive(1'b0, 2'b00, 1'b0, 1'b0);
        checkAll("reset_mid", 1'b0, 2'b00, 2'b00, 1'b0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
